// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: ownership state encoding,
// port indices and the round-robin tie-break helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // On a tie the port that did not win last time gets the slot.
    function automatic logic rr_pick(input logic last_winner);
        return ~last_winner;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Port 0 (CPU) and port 1 (DMA/debug) compete per cycle; a port holding lock
// keeps ownership for up to MAX_BURST consecutive grants, after which the
// other port gets a turn. Read data comes back one cycle after the grant and
// is steered to the requesting port by rvalid0/rvalid1.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nobody owns the memory; round-robin on a tie
// OWN0    | port 0 holds a lock; it wins whenever req0 is high
// OWN1    | port 1 holds a lock; it wins whenever req1 is high
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,

    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,

    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_upd;
    logic             last_q, last_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;

    logic             win_any;
    logic             win_port;
    logic             own_hit;
    logic             win_lock;
    logic             win_we;

    // Winner selection: a live owner beats everything, otherwise single
    // requester or round-robin. Reset forces no grant so nothing reaches the
    // memory while rst_n is low.
    always_comb begin
        win_any  = 1'b0;
        win_port = PORT0;
        own_hit  = 1'b0;
        if (state_q == ST_OWN0 && req0) begin
            win_any  = 1'b1;
            win_port = PORT0;
            own_hit  = 1'b1;
        end else if (state_q == ST_OWN1 && req1) begin
            win_any  = 1'b1;
            win_port = PORT1;
            own_hit  = 1'b1;
        end else if (req0 && req1) begin
            win_any  = 1'b1;
            win_port = rr_pick(last_q);
        end else if (req0) begin
            win_any  = 1'b1;
            win_port = PORT0;
        end else if (req1) begin
            win_any  = 1'b1;
            win_port = PORT1;
        end
        if (!rst_n) begin
            win_any = 1'b0;
            own_hit = 1'b0;
        end
        win_lock = (win_port == PORT1) ? lock1 : lock0;
        win_we   = (win_port == PORT1) ? we1   : we0;
    end

    // Grant strobes and memory command, zeroed when there is no winner.
    always_comb begin
        gnt0      = win_any && (win_port == PORT0);
        gnt1      = win_any && (win_port == PORT1);
        mem_en    = win_any;
        mem_we    = win_any && win_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (win_any) begin
            mem_addr  = (win_port == PORT1) ? addr1  : addr0;
            mem_wdata = (win_port == PORT1) ? wdata1 : wdata0;
        end
    end

    // Next ownership, burst count, last winner and read-return flags.
    // A grant that did not come from a live owner starts a fresh burst at 1.
    always_comb begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        last_d    = last_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        cnt_upd   = own_hit ? (cnt_q + CNT_ONE) : CNT_ONE;
        if (win_any) begin
            last_d = win_port;
            if (win_lock && (cnt_upd < BURST_LIM)) begin
                state_d = (win_port == PORT1) ? ST_OWN1 : ST_OWN0;
                cnt_d   = cnt_upd;
            end
            rvalid0_d = !win_we && (win_port == PORT0);
            rvalid1_d = !win_we && (win_port == PORT1);
        end
    end

    // State registers; last winner resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= PORT1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // Memory read data is shared; rvalid tells each port whether it is theirs.
    always_comb begin
        rvalid0 = rvalid0_q;
        rvalid1 = rvalid1_q;
        rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a rule-level model.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0, lock0, we0, req1, lock1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory driven only by the DUT's command port.
    logic [DW-1:0] sram [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    // Reference model: owner (-1 none), burst length so far, last winner,
    // pending read return port (-1 none) and the data it must carry.
    int            m_owner, m_cnt, m_last, m_rv;
    logic [DW-1:0] m_rv_data;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};

    int            n_err = 0;
    int            n_chk = 0;
    int            got_w, got_rv;
    logic [DW-1:0] got_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_rv    = -1;
    endtask

    function automatic int model_pick();
        bit r [2];
        r[0] = req0;
        r[1] = req1;
        if (m_owner >= 0 && r[m_owner]) return m_owner;
        if (r[0] && r[1]) return 1 - m_last;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    task automatic model_commit(input int w);
        int            newcnt;
        bit            lk, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (w < 0) begin
            m_owner = -1;
            m_cnt   = 0;
            m_rv    = -1;
            return;
        end
        lk     = (w == 0) ? lock0  : lock1;
        wr     = (w == 0) ? we0    : we1;
        a      = (w == 0) ? addr0  : addr1;
        d      = (w == 0) ? wdata0 : wdata1;
        newcnt = (m_owner == w) ? m_cnt + 1 : 1;
        if (lk && newcnt < MB) begin
            m_owner = w;
            m_cnt   = newcnt;
        end else begin
            m_owner = -1;
            m_cnt   = 0;
        end
        m_last = w;
        if (wr) begin
            ref_mem[a] = d;
            m_rv       = -1;
        end else begin
            m_rv      = w;
            m_rv_data = ref_mem[a];
        end
    endtask

    // One clock cycle: inputs already applied at posedge+1; compare at
    // posedge+3, optionally pulse reset across the next edge, then advance model.
    task automatic step(input bit rst_pulse);
        int            w;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ewe;
        #2;
        w      = model_pick();
        got_w  = (gnt0 && gnt1) ? -2 : gnt0 ? 0 : gnt1 ? 1 : -1;
        got_rv = (rvalid0 && rvalid1) ? -2 : rvalid0 ? 0 : rvalid1 ? 1 : -1;
        got_rdata = rdata;
        ea  = (w == 0) ? addr0  : (w == 1) ? addr1  : '0;
        ed  = (w == 0) ? wdata0 : (w == 1) ? wdata1 : '0;
        ewe = (w == 0) ? we0    : (w == 1) ? we1    : 1'b0;
        chk("winner",    64'(got_w), 64'(w));
        chk("mem_en",    64'(mem_en), 64'(w >= 0));
        chk("mem_we",    64'(mem_we), 64'(ewe));
        chk("mem_addr",  64'(mem_addr), 64'(ea));
        chk("mem_wdata", 64'(mem_wdata), 64'(ed));
        chk("rvalid",    64'(got_rv), 64'(m_rv));
        if (m_rv >= 0) chk("rdata", 64'(got_rdata), 64'(m_rv_data));
        if (rst_pulse) begin
            rst_n = 1'b0;
            #1;
            chk("gnt_in_reset", 64'({gnt0, gnt1, mem_en}), 64'(0));
        end
        @(posedge clk);
        if (rst_pulse) model_reset();
        else           model_commit(w);
        #1;
        if (rst_pulse) rst_n = 1'b1;
    endtask

    task automatic drive(input bit r0, input bit l0, input bit w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input bit r1, input bit l1, input bit w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    int seq34 [4] = '{0, 1, 0, 1};
    int seq36 [6] = '{1, 1, 1, 1, 0, 1};

    initial begin
        model_reset();
        drive(1, 1, 0, 8'h01, 32'h0, 1, 1, 0, 8'h02, 32'h0);
        #3;
        chk("reset_gnt_memen", 64'({gnt0, gnt1, mem_en}), 64'(0));
        chk("reset_rvalid",    64'({rvalid0, rvalid1}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both request without lock: strict alternation starting with port 0.
        drive(1, 0, 0, 8'h20, 32'h0, 1, 0, 0, 8'h21, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(0);
            chk("rr_alternate", 64'(got_w), 64'(seq34[i]));
            chk("rr_mem_en", 64'(mem_en), 64'(1));
        end
        drive(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 8'h0, 32'h0);
        step(0);

        // Write from port 0, read back from port 1.
        drive(1, 0, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 8'h0, 32'h0);
        step(0);
        chk("wr_gnt0", 64'(got_w), 64'(0));
        drive(0, 0, 0, 8'h0, 32'h0, 1, 0, 0, 8'h10, 32'h0);
        step(0);
        chk("rd_gnt1", 64'(got_w), 64'(1));
        drive(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 8'h0, 32'h0);
        step(0);
        chk("rd_rvalid1", 64'(got_rv), 64'(1));
        chk("rd_rdata", 64'(got_rdata), 64'(32'hDEADBEEF));

        // Port 1 locks for MAX_BURST grants, then port 0 gets one, then port 1.
        for (int i = 0; i < 6; i++) begin
            drive(i > 0, 0, 1, 8'h30, 32'(i), 1, 1, 1, 8'h31, 32'(100 + i));
            step(0);
            chk("burst_seq", 64'(got_w), 64'(seq36[i]));
        end
        drive(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 8'h0, 32'h0);
        step(0);

        // Owner drops its request: the other port wins in that same cycle.
        drive(1, 1, 1, 8'h40, 32'h1, 0, 0, 1, 8'h41, 32'h2);
        step(0);
        chk("own0_gnt", 64'(got_w), 64'(0));
        drive(0, 1, 1, 8'h40, 32'h1, 1, 0, 1, 8'h41, 32'h2);
        step(0);
        chk("own0_void_gnt1", 64'(got_w), 64'(1));
        drive(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 8'h0, 32'h0);
        step(0);

        // Reset pulsed across a read grant: no rvalid after, port 0 wins the tie.
        drive(0, 0, 0, 8'h0, 32'h0, 1, 1, 0, 8'h10, 32'h0);
        step(1);
        chk("pre_reset_gnt1", 64'(got_w), 64'(1));
        drive(1, 0, 1, 8'h50, 32'h5, 1, 0, 1, 8'h51, 32'h6);
        step(0);
        chk("post_reset_no_rvalid", 64'(got_rv), 64'(-1));
        chk("post_reset_gnt0", 64'(got_w), 64'(0));

        // Idle bus.
        drive(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 8'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("idle_gnt", 64'(got_w), 64'(-1));
            chk("idle_rvalid", 64'(got_rv), 64'(-1));
            chk("idle_mem_en", 64'(mem_en), 64'(0));
        end

        // Randomized traffic over a small address window with rare reset pulses.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 15)), $urandom);
            step($urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
